// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the digit-serial multiplier sequencer.
package seq_mult_pkg;

  localparam int P     = 2;
  localparam int N_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    LAST,
    DRAIN
  } state_e;

  // Operand width code to digit count N (W = 2N).
  function automatic logic [3:0] mode_to_n(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/seq_mult_col_cnt.sv
// Column-major digit index walker: k = i + j, i descending within each column.
module seq_mult_col_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       adv_i,
  input  logic [3:0] n_i,
  output logic [2:0] i_o,
  output logic [2:0] j_o,
  output logic [3:0] k_o,
  output logic       col_end_o,
  output logic       done_o
);
  import seq_mult_pkg::*;

  localparam int IW = $clog2(N_MAX);

  logic [3:0]    k_q;
  logic [IW-1:0] i_q;
  logic [3:0]    i_lo;
  logic [3:0]    k_nxt;
  logic [3:0]    i_hi;
  logic [4:0]    k_final;

  always_comb begin
    i_lo    = (k_q >= n_i) ? (k_q - n_i + 4'd1) : 4'd0;
    k_nxt   = k_q + 4'd1;
    i_hi    = (k_nxt < n_i) ? k_nxt : (n_i - 4'd1);
    k_final = {n_i, 1'b0} - 5'd2;
  end

  assign col_end_o = ({1'b0, i_q} == i_lo);
  assign done_o    = col_end_o && ({1'b0, k_q} == k_final);
  assign i_o       = i_q;
  // j never exceeds N-1, so the 3-bit wrap of k-i is exact
  assign j_o       = k_q[2:0] - i_q;
  assign k_o       = k_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q <= 4'd0;
      i_q <= '0;
    end else if (clr_i) begin
      k_q <= 4'd0;
      i_q <= '0;
    end else if (adv_i) begin
      if (col_end_o) begin
        k_q <= k_nxt;
        i_q <= i_hi[IW-1:0];
      end else begin
        i_q <= i_q - 3'd1;
      end
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the 2-bit digit-serial multiplier datapath; collects product digits LSB-first.
// Define SEQ_MULT_CTRL_PIPE_EN for a datapath with one extra output pipeline stage.
module seq_mult_ctrl #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [MAX_WIDTH-1:0] req_a_i,
  input  logic [MAX_WIDTH-1:0] req_b_i,
  input  logic [1:0]           req_mode_i,
  input  logic                 req_signed_i,
  output logic [MAX_WIDTH-1:0] dp_a_o,
  output logic [MAX_WIDTH-1:0] dp_b_o,
  output logic                 dp_start_o,
  output logic [2:0]           dp_sel_a_o,
  output logic [2:0]           dp_sel_b_o,
  output logic                 dp_count_down_o,
  output logic                 dp_count_last2_o,
  output logic                 dp_last_out_o,
  output logic                 dp_inv_first_o,
  output logic                 dp_inv_row_o,
  output logic                 dp_place_one_o,
  output logic [1:0]           dp_shift_in_o,
  output logic [7:0]           dp_init_sum_o,
  input  logic [P-1:0]         dp_p_i,
  output logic                 dig_valid_o,
  output logic                 dig_last_o,
  output logic [P-1:0]         dig_data_o,
  output logic                 busy_o
);
  import seq_mult_pkg::*;

  state_e     state, state_nxt;
  logic [3:0] n_q;
  logic       sgn_q;
  logic [2:0] idx_i, idx_j;
  logic [3:0] col_k;
  logic       col_end, mac_done;
  logic       accept, drain_done;
  logic       strobe_p0, last_p0;
  logic       vld_p1, last_p1;

  // Right-aligned W-bit operand to full width, sign- or zero-extended.
  function automatic logic [MAX_WIDTH-1:0] extend_op(input logic [MAX_WIDTH-1:0] v,
                                                     input logic [3:0] n, input logic sgn);
    logic [MAX_WIDTH-1:0] mask;
    logic [3:0]           msb;
    mask = ~({MAX_WIDTH{1'b1}} << {n, 1'b0});
    msb  = {n[2:0], 1'b0} - 4'd1;
    if (sgn && v[msb]) return v | ~mask;
    return v & mask;
  endfunction

  assign accept = (state == IDLE) && req_valid_i;

  seq_mult_col_cnt u_col_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state == LOAD),
    .adv_i     (state == MAC),
    .n_i       (n_q),
    .i_o       (idx_i),
    .j_o       (idx_j),
    .k_o       (col_k),
    .col_end_o (col_end),
    .done_o    (mac_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      n_q    <= 4'd1;
      sgn_q  <= 1'b0;
      dp_a_o <= '0;
      dp_b_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        n_q    <= mode_to_n(req_mode_i);
        sgn_q  <= req_signed_i;
        dp_a_o <= extend_op(req_a_i, mode_to_n(req_mode_i), req_signed_i);
        dp_b_o <= extend_op(req_b_i, mode_to_n(req_mode_i), req_signed_i);
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    req_ready_o      = (state == IDLE);
    busy_o           = (state != IDLE);
    dp_start_o       = (state == LOAD);
    dp_count_down_o  = (state == MAC);
    dp_sel_a_o       = 3'd0;
    dp_sel_b_o       = 3'd0;
    dp_count_last2_o = 1'b0;
    dp_last_out_o    = (state == LAST);
    dp_inv_first_o   = 1'b0;
    dp_inv_row_o     = 1'b0;
    dp_place_one_o   = 1'b0;
    dp_shift_in_o    = 2'b00;
    dp_init_sum_o    = 8'h00;
    if (state == MAC) begin
      dp_sel_a_o       = idx_i;
      dp_sel_b_o       = idx_j;
      dp_count_last2_o = col_end;
      dp_inv_first_o   = sgn_q && (idx_i == n_q[2:0] - 3'd1);
      dp_inv_row_o     = sgn_q && (idx_j == n_q[2:0] - 3'd1);
      // Baugh-Wooley correction one enters at the shift closing column N-1
      dp_place_one_o   = sgn_q && col_end && (col_k == n_q - 4'd1);
      dp_shift_in_o    = dp_place_one_o ? 2'b01 : 2'b00;
    end
    if (state == LOAD && sgn_q && n_q == 4'd1) dp_init_sum_o = 8'h01;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = LOAD;
      LOAD:    state_nxt = MAC;
      MAC:     if (mac_done) state_nxt = LAST;
      LAST:    state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign strobe_p0 = dp_count_last2_o | dp_last_out_o;
  assign last_p0   = dp_last_out_o;

  // p0 -> p1: datapath presents the digit one cycle after each shift/last strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= strobe_p0;
      last_p1 <= last_p0;
    end
  end

`ifdef SEQ_MULT_CTRL_PIPE_EN
  logic vld_p2, last_p2;

  // p1 -> p2: extra wait for the pipelined datapath output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  assign dig_valid_o = vld_p2;
  assign dig_last_o  = last_p2;
`else
  assign dig_valid_o = vld_p1;
  assign dig_last_o  = last_p1;
`endif

  // DRAIN ends exactly when the final digit is handed out
  assign drain_done = dig_last_o;
  assign dig_data_o = dig_valid_o ? dp_p_i : '0;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl with a behavioural datapath and a digit scoreboard.
module tb_seq_mult_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [15:0] req_a_i = '0;
  logic [15:0] req_b_i = '0;
  logic [1:0]  req_mode_i = '0;
  logic        req_signed_i = 1'b0;
  logic [15:0] dp_a_o, dp_b_o;
  logic        dp_start_o;
  logic [2:0]  dp_sel_a_o, dp_sel_b_o;
  logic        dp_count_down_o, dp_count_last2_o, dp_last_out_o;
  logic        dp_inv_first_o, dp_inv_row_o, dp_place_one_o;
  logic [1:0]  dp_shift_in_o;
  logic [7:0]  dp_init_sum_o;
  logic [1:0]  dp_p_i = '0;
  logic        dig_valid_o, dig_last_o;
  logic [1:0]  dig_data_o;
  logic        busy_o;

  typedef struct {
    logic [1:0] d;
    logic       last;
    int         idx;
    int         acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          first_lat = -1, last_lat = -1, last_cyc = -1, ndig = 0;
  logic [31:0] res = '0;

  logic        dp_sgn = 1'b0;
  logic [31:0] dp_prod = '0;
  int          dp_idx = 0;
  logic [31:0] dp_ea, dp_eb;

  seq_mult_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_a_i          (req_a_i),
    .req_b_i          (req_b_i),
    .req_mode_i       (req_mode_i),
    .req_signed_i     (req_signed_i),
    .dp_a_o           (dp_a_o),
    .dp_b_o           (dp_b_o),
    .dp_start_o       (dp_start_o),
    .dp_sel_a_o       (dp_sel_a_o),
    .dp_sel_b_o       (dp_sel_b_o),
    .dp_count_down_o  (dp_count_down_o),
    .dp_count_last2_o (dp_count_last2_o),
    .dp_last_out_o    (dp_last_out_o),
    .dp_inv_first_o   (dp_inv_first_o),
    .dp_inv_row_o     (dp_inv_row_o),
    .dp_place_one_o   (dp_place_one_o),
    .dp_shift_in_o    (dp_shift_in_o),
    .dp_init_sum_o    (dp_init_sum_o),
    .dp_p_i           (dp_p_i),
    .dig_valid_o      (dig_valid_o),
    .dig_last_o       (dig_last_o),
    .dig_data_o       (dig_data_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural datapath: product taken at load, one digit per strobe, presented next cycle
  assign dp_ea = dp_sgn ? {{16{dp_a_o[15]}}, dp_a_o} : {16'h0, dp_a_o};
  assign dp_eb = dp_sgn ? {{16{dp_b_o[15]}}, dp_b_o} : {16'h0, dp_b_o};

  always @(posedge clk_i) begin
    if (dp_start_o) begin
      dp_prod <= dp_ea * dp_eb;
      dp_idx  <= 0;
    end else if (dp_count_last2_o || dp_last_out_o) begin
      dp_p_i <= dp_prod[2*dp_idx +: 2];
      dp_idx <= dp_idx + 1;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                       input logic s, output int acc);
    int          n, w;
    logic [31:0] mask, pa, pb, pr;
    exp_t        e;
    n    = 1 << m;
    w    = 2 * n;
    mask = (32'h1 << w) - 32'h1;
    pa   = {16'h0, a} & mask;
    pb   = {16'h0, b} & mask;
    if (s && a[w-1]) pa = pa | ~mask;
    if (s && b[w-1]) pb = pb | ~mask;
    pr = pa * pb;
    @(negedge clk_i);
    req_a_i      = a;
    req_b_i      = b;
    req_mode_i   = m;
    req_signed_i = s;
    req_valid_i  = 1'b1;
    dp_sgn       = s;
    for (int t = 0; t < 300 && req_ready_o !== 1'b1; t++) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout: ready=%b, expected 1", req_ready_o);
      acc = -1;
    end else begin
      acc = cyc + 1;
      for (int k = 0; k < 2 * n; k++) begin
        e.d    = pr[2*k +: 2];
        e.last = (k == 2 * n - 1);
        e.idx  = k;
        e.acc  = acc;
        sb.push_back(e);
      end
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    for (int t = 0; t < 300 && !(req_ready_o === 1'b1 && sb.size() == 0); t++) @(negedge clk_i);
    ok = (req_ready_o === 1'b1 && sb.size() == 0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_busy: ready=%b busy=%b, expected 1 0", req_ready_o, busy_o);
    end
    checks++;
    if ({dp_start_o, dp_count_down_o, dp_count_last2_o, dp_last_out_o, dp_inv_first_o,
         dp_inv_row_o, dp_place_one_o, dp_shift_in_o, dp_sel_a_o, dp_sel_b_o} !== 15'b0 ||
        dp_init_sum_o !== 8'h00) begin
      fails++;
      $display("FAIL reset_dp_ctrl: start=%b cd=%b l2=%b lo=%b sel=%0d/%0d init=%h, expected all 0",
               dp_start_o, dp_count_down_o, dp_count_last2_o, dp_last_out_o,
               dp_sel_a_o, dp_sel_b_o, dp_init_sum_o);
    end
    checks++;
    if (dp_a_o !== 16'h0 || dp_b_o !== 16'h0) begin
      fails++;
      $display("FAIL reset_operands: a=%h b=%h, expected 0 0", dp_a_o, dp_b_o);
    end
    checks++;
    if (dig_valid_o !== 1'b0 || dig_last_o !== 1'b0 || dig_data_o !== 2'b00) begin
      fails++;
      $display("FAIL reset_dig: valid=%b last=%b data=%0d, expected 0 0 0",
               dig_valid_o, dig_last_o, dig_data_o);
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: ready=%b busy=%b, expected 1 0", req_ready_o, busy_o);
    end
  endtask

  task automatic test_unsigned_w4();
    int acc, cnt;
    bit ok;
    issue(16'd13, 16'd11, 2'b01, 1'b0, acc);
    checks++;
    if (dp_start_o !== 1'b1 || dp_a_o !== 16'd13 || dp_b_o !== 16'd11) begin
      fails++;
      $display("FAIL u4_load: start=%b a=%h b=%h, expected 1 000d 000b", dp_start_o, dp_a_o, dp_b_o);
    end
    cnt = 0;
    for (int t = 0; t < 100 && req_ready_o !== 1'b1; t++) begin
      cnt++;
      @(negedge clk_i);
    end
    checks++;
    if (cnt !== 7) begin
      fails++;
      $display("FAIL u4_ready_low: %0d cycles, expected 7", cnt);
    end
    wait_idle(ok);
    checks++;
    if (!ok || ndig !== 4 || res !== 32'h8F) begin
      fails++;
      $display("FAIL u4_result: ok=%0d digits=%0d value=%h, expected 1 4 0000008f", ok, ndig, res);
    end
    checks++;
    if (first_lat !== 2 || last_lat !== 6) begin
      fails++;
      $display("FAIL u4_latency: first=%0d last=%0d, expected 2 6", first_lat, last_lat);
    end
  endtask

  task automatic test_signed_w4();
    int          acc;
    bit          ok;
    logic [12:0] got;
    // {count_down, sel_a, sel_b, last2, place_one, inv_first, inv_row, shift_in}
    logic [12:0] exp_mac [4] = '{13'b1_000_000_1_0_0_0_00, 13'b1_001_000_0_0_1_0_00,
                                 13'b1_000_001_1_1_0_1_01, 13'b1_001_001_1_0_1_1_00};
    issue(16'h000D, 16'h0005, 2'b01, 1'b1, acc);
    checks++;
    if (dp_a_o !== 16'hFFFD || dp_b_o !== 16'h0005 || dp_init_sum_o !== 8'h00) begin
      fails++;
      $display("FAIL s4_load: a=%h b=%h init=%h, expected fffd 0005 00", dp_a_o, dp_b_o, dp_init_sum_o);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      got = {dp_count_down_o, dp_sel_a_o, dp_sel_b_o, dp_count_last2_o, dp_place_one_o,
             dp_inv_first_o, dp_inv_row_o, dp_shift_in_o};
      checks++;
      if (got !== exp_mac[c]) begin
        fails++;
        $display("FAIL s4_mac_cycle%0d: ctrl=%b, expected %b", c, got, exp_mac[c]);
      end
    end
    @(negedge clk_i);
    checks++;
    if (dp_last_out_o !== 1'b1 || dp_count_down_o !== 1'b0) begin
      fails++;
      $display("FAIL s4_last: last_out=%b count_down=%b, expected 1 0", dp_last_out_o, dp_count_down_o);
    end
    wait_idle(ok);
    checks++;
    if (!ok || ndig !== 4 || res !== 32'hF1) begin
      fails++;
      $display("FAIL s4_result: ok=%0d digits=%0d value=%h, expected 1 4 000000f1", ok, ndig, res);
    end
  endtask

  task automatic test_unsigned_w16();
    int acc;
    bit ok;
    issue(16'hFFFF, 16'hFFFF, 2'b11, 1'b0, acc);
    wait_idle(ok);
    checks++;
    if (!ok || ndig !== 16 || res !== 32'hFFFE0001) begin
      fails++;
      $display("FAIL u16_result: ok=%0d digits=%0d value=%h, expected 1 16 fffe0001", ok, ndig, res);
    end
    checks++;
    if (first_lat !== 2 || last_lat !== 66) begin
      fails++;
      $display("FAIL u16_latency: first=%0d last=%0d, expected 2 66", first_lat, last_lat);
    end
  endtask

  task automatic test_signed_w2();
    int acc;
    bit ok;
    issue(16'h0002, 16'h0002, 2'b00, 1'b1, acc);
    checks++;
    if (dp_init_sum_o !== 8'h01 || dp_a_o !== 16'hFFFE) begin
      fails++;
      $display("FAIL s2_load: init=%h a=%h, expected 01 fffe", dp_init_sum_o, dp_a_o);
    end
    @(negedge clk_i);
    checks++;
    if (dp_count_last2_o !== 1'b1 || dp_last_out_o !== 1'b0 ||
        dp_place_one_o !== 1'b1 || dp_shift_in_o !== 2'b01) begin
      fails++;
      $display("FAIL s2_mac: last2=%b last_out=%b place=%b shift=%b, expected 1 0 1 01",
               dp_count_last2_o, dp_last_out_o, dp_place_one_o, dp_shift_in_o);
    end
    @(negedge clk_i);
    checks++;
    if (dp_last_out_o !== 1'b1 || dp_count_last2_o !== 1'b0) begin
      fails++;
      $display("FAIL s2_last: last_out=%b last2=%b, expected 1 0", dp_last_out_o, dp_count_last2_o);
    end
    wait_idle(ok);
    checks++;
    if (!ok || ndig !== 2 || res !== 32'h4 || first_lat !== 2 || last_lat !== 3) begin
      fails++;
      $display("FAIL s2_result: ok=%0d digits=%0d value=%h lat=%0d/%0d, expected 1 2 00000004 2/3",
               ok, ndig, res, first_lat, last_lat);
    end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b;
    bit ok;
    issue(16'd7, 16'd9, 2'b01, 1'b0, acc_a);
    issue(16'h0008, 16'h0008, 2'b01, 1'b1, acc_b);
    // Handshake cycle (acc_b-1) must be the one right after the first dig_last
    checks++;
    if (acc_b !== last_cyc + 2) begin
      fails++;
      $display("FAIL b2b_accept: handshake cycle %0d, expected %0d", acc_b - 1, last_cyc + 1);
    end
    checks++;
    if (ndig !== 4 || res !== 32'h3F) begin
      fails++;
      $display("FAIL b2b_first: digits=%0d value=%h, expected 4 0000003f", ndig, res);
    end
    wait_idle(ok);
    checks++;
    if (!ok || ndig !== 4 || res !== 32'h40) begin
      fails++;
      $display("FAIL b2b_second: ok=%0d digits=%0d value=%h, expected 1 4 00000040", ok, ndig, res);
    end
  endtask

  task automatic test_reset_mid_mac();
    int acc, cnt;
    bit ok;
    issue(16'h00A5, 16'h003C, 2'b10, 1'b0, acc);
    repeat (6) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || dp_count_down_o !== 1'b0 ||
        dig_valid_o !== 1'b0 || dp_a_o !== 16'h0) begin
      fails++;
      $display("FAIL abort_outputs: busy=%b ready=%b cd=%b dv=%b a=%h, expected 0 1 0 0 0000",
               busy_o, req_ready_o, dp_count_down_o, dig_valid_o, dp_a_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (dig_valid_o !== 1'b0 || busy_o !== 1'b0) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      fails++;
      $display("FAIL abort_quiet: %0d active cycles after reset, expected 0", cnt);
    end
    issue(16'd200, 16'd150, 2'b10, 1'b0, acc);
    wait_idle(ok);
    checks++;
    if (!ok || ndig !== 8 || res !== 32'h7530 || last_lat !== 18) begin
      fails++;
      $display("FAIL abort_recover: ok=%0d digits=%0d value=%h last=%0d, expected 1 8 00007530 18",
               ok, ndig, res, last_lat);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_i);
        if (dig_valid_o === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_digit: data=%0d last=%b at cycle %0d, expected no digit",
                     dig_data_o, dig_last_o, cyc);
          end else begin
            mon_e = sb.pop_front();
            if (dig_data_o !== mon_e.d || dig_last_o !== mon_e.last) begin
              fails++;
              $display("FAIL digit%0d: data=%0d last=%b, expected data=%0d last=%b",
                       mon_e.idx, dig_data_o, dig_last_o, mon_e.d, mon_e.last);
            end
            if (mon_e.idx == 0) begin
              res       = '0;
              ndig      = 0;
              first_lat = cyc - mon_e.acc;
            end
            res[2*mon_e.idx +: 2] = dig_data_o;
            ndig++;
            if (mon_e.last) begin
              last_lat = cyc - mon_e.acc;
              last_cyc = cyc;
            end
          end
        end
      end
    join_none

    test_reset();
    test_unsigned_w4();
    test_signed_w4();
    test_unsigned_w16();
    test_signed_w2();
    test_back_to_back();
    test_reset_mid_mac();
    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
